sfifo_wr_arb: RTL and testbench

Round-robin write-side arbiter that shares one `sfifo` write port among `NUM_REQ` requesters. Each requester presents data under a valid/accept handshake. The arbiter grants the port to one owner at a time, for a burst of up to `MAX_BURST` beats, and drives the FIFO's `wr`/`data_in` while honouring `sfifo_full` back-pressure. It sits directly in front of an `sfifo` instance in single-clock configuration.

---
 rtl/sfifo_wr_arb.sv | 164 ++++++++++++++++
 tb/tb_sfifo_wr_arb.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/sfifo_wr_arb.sv
// sfifo_wr_arb: round-robin arbiter sharing one single-clock sfifo write port
// among NUM_REQ valid/accept requesters.
//
// Optional feature macro: SFIFO_ARB_BURST_EN
//   defined   : a grant lasts up to MAX_BURST beats or until req_last.
//   undefined : every grant is exactly one beat; req_last is ignored and no
//               beat counter exists.
//
// state | meaning
// IDLE  | no owner; choose next requester searching from last_owner+1
// BURST | owner holds the port; a beat moves when req[owner] & ~sfifo_full

module sfifo_wr_arb #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 8,
  parameter int MAX_BURST  = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_REQ-1:0]            req,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  input  logic [NUM_REQ-1:0]            req_last,
  output logic [NUM_REQ-1:0]            gnt,
  input  logic                          sfifo_full,
  output logic                          sfifo_wr,
  output logic [DATA_WIDTH-1:0]         sfifo_data,
  output logic [$clog2(NUM_REQ)-1:0]    owner,
  output logic                          busy
);

  localparam int OWN_W = $clog2(NUM_REQ);

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_BURST = 1'b1
  } state_t;

  state_t           state;
  logic [OWN_W-1:0] last_owner;
  logic [OWN_W-1:0] nxt_owner;
  logic             own_req;
  logic             accept;
  logic             last_beat;

  // First requester at or after last_owner+1, wrapping; only used when req != 0.
  function automatic logic [OWN_W-1:0] rr_pick(input logic [NUM_REQ-1:0] r,
                                               input logic [OWN_W-1:0]   last);
    logic [OWN_W-1:0] pick;
    logic [OWN_W-1:0] idx;
    logic             found;
    pick  = '0;
    found = 1'b0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = OWN_W'((int'(last) + k) % NUM_REQ);
      if (!found && r[idx]) begin
        pick  = idx;
        found = 1'b1;
      end
    end
    return pick;
  endfunction

  assign nxt_owner = rr_pick(req, last_owner);

  // Valid bit of the current owner.
  always_comb begin
    own_req = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (owner == OWN_W'(i)) own_req = req[i];
    end
  end

  assign accept = (state == S_BURST) && own_req && !sfifo_full;
  assign busy   = (state == S_BURST);

`ifdef SFIFO_ARB_BURST_EN
  localparam int CNT_W = $clog2(MAX_BURST + 1);

  logic [CNT_W-1:0] beat_cnt;
  logic             own_last;

  // Last-beat marker of the current owner.
  always_comb begin
    own_last = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (owner == OWN_W'(i)) own_last = req_last[i];
    end
  end

  assign last_beat = own_last || (beat_cnt == CNT_W'(MAX_BURST - 1));

  // Beats accepted in the current grant; frozen while the FIFO is full.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      beat_cnt <= '0;
    end else if (state == S_IDLE) begin
      beat_cnt <= '0;
    end else if (accept) begin
      beat_cnt <= beat_cnt + 1'b1;
    end
  end
`else
  // Single-beat grants: every accepted beat closes the grant.
  localparam int unused_max_burst = MAX_BURST;
  logic unused_req_last;
  assign unused_req_last = ^req_last;
  assign last_beat       = 1'b1;
`endif

  // One-hot accept towards the owning requester.
  always_comb begin
    gnt = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (accept && (owner == OWN_W'(i))) gnt[i] = 1'b1;
    end
  end

  assign sfifo_wr = accept;

  // Owner's data is forwarded throughout BURST, zero otherwise.
  always_comb begin
    sfifo_data = '0;
    if (state == S_BURST) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (owner == OWN_W'(i)) sfifo_data = req_data[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  // Arbitration in IDLE, burst termination (last beat or abandon) in BURST.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      owner      <= '0;
      last_owner <= OWN_W'(NUM_REQ - 1);
    end else begin
      case (state)
        S_IDLE: begin
          if (|req) begin
            owner <= nxt_owner;
            state <= S_BURST;
          end
        end
        S_BURST: begin
          if (!own_req) begin
            state      <= S_IDLE;
            last_owner <= owner;
          end else if (accept && last_beat) begin
            state      <= S_IDLE;
            last_owner <= owner;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Never write into a full FIFO, and accept at most one requester per cycle.
  a_no_wr_full: assert property (@(posedge clk) disable iff (!rst_n)
                                 !(sfifo_wr && sfifo_full));
  a_gnt_onehot: assert property (@(posedge clk) disable iff (!rst_n)
                                 $onehot0(gnt));

endmodule

// File: tb/tb_sfifo_wr_arb.sv
// Scoreboard bench for sfifo_wr_arb: stimulus pushes the expected
// (owner, data, cycle) of each FIFO write; a negedge monitor pops and compares.
module tb_sfifo_wr_arb;

  localparam int NR = 4;
  localparam int DW = 8;
  localparam int MB = 4;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [NR-1:0]    req;
  logic [NR*DW-1:0] req_data;
  logic [NR-1:0]    req_last;
  logic [NR-1:0]    gnt;
  logic             sfifo_full = 1'b0;
  logic             sfifo_wr;
  logic [DW-1:0]    sfifo_data;
  logic [1:0]       owner;
  logic             busy;

  typedef struct {
    int         own;
    logic [7:0] data;
    int         cyc;
  } exp_t;

  exp_t          exp_q[$];
  int            rem [NR];
  logic [NR-1:0] last_mark = '0;
  logic [5:0]    seq [NR] = '{default: 6'd0};
  logic [5:0]    exp_seq [NR] = '{default: 6'd0};
  logic [NR-1:0] xfer = '0;
  int            cyc = 0;
  int            n_chk = 0;
  int            n_err = 0;

  sfifo_wr_arb #(.NUM_REQ(NR), .DATA_WIDTH(DW), .MAX_BURST(MB)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req        (req),
    .req_data   (req_data),
    .req_last   (req_last),
    .gnt        (gnt),
    .sfifo_full (sfifo_full),
    .sfifo_wr   (sfifo_wr),
    .sfifo_data (sfifo_data),
    .owner      (owner),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  // Requesters: valid while beats remain; data = {index, per-requester sequence}.
  always_comb begin
    for (int i = 0; i < NR; i++) begin
      req[i]                = (rem[i] != 0);
      req_last[i]           = last_mark[i] && (rem[i] == 1);
      req_data[i*DW +: DW]  = {2'(i), seq[i]};
    end
  end

  always @(posedge clk) begin
    cyc  <= cyc + 1;
    xfer <= req & gnt;
    for (int i = 0; i < NR; i++) begin
      if (req[i] && gnt[i]) seq[i] <= seq[i] + 6'd1;
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push(input int o, input int c);
    exp_t e;
    e.own  = o;
    e.data = {2'(o), exp_seq[o]};
    e.cyc  = c;
    exp_q.push_back(e);
    exp_seq[o] = exp_seq[o] + 6'd1;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    for (int i = 0; i < NR; i++) begin
      if (xfer[i] && rem[i] > 0) rem[i] = rem[i] - 1;
    end
  endtask

  task automatic wait_drain(input int budget);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      step();
      n++;
    end
    if (exp_q.size() != 0) begin
      chk("drain_timeout_pending", exp_q.size(), 0);
      exp_q.delete();
    end
  endtask

  // Monitor: every FIFO write must match the head of the scoreboard.
  always @(negedge clk) begin
    if (rst_n) begin
      if (sfifo_full) chk("wr_while_full", sfifo_wr, 0);
      if (sfifo_wr) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_wr_gnt", gnt, 0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("wr_gnt", gnt, 1 << e.own);
          chk("wr_data", sfifo_data, e.data);
          chk("wr_cycle", cyc, e.cyc);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int t0;
    int r;
    int pre;
    for (int i = 0; i < NR; i++) rem[i] = 0;
    repeat (3) step();
    chk("rst_gnt", gnt, 0);
    chk("rst_wr", sfifo_wr, 0);
    chk("rst_busy", busy, 0);
    rst_n = 1'b1;
    step();
    chk("post_rst_owner", owner, 0);
    chk("post_rst_busy", busy, 0);
    chk("post_rst_data", sfifo_data, 0);
    chk("post_rst_gnt", gnt, 0);

    // All four requesting from reset: rotation starts at requester 0.
    t0 = cyc;
`ifdef SFIFO_ARB_BURST_EN
    for (int o = 0; o < NR; o++)
      for (int b = 0; b < MB; b++) push(o, t0 + 1 + 5*o + b);
    for (int o = 0; o < NR; o++) push(o, t0 + 21 + 3*o);
`else
    for (int k = 0; k < 20; k++) push(k % NR, t0 + 1 + 2*k);
`endif
    for (int i = 0; i < NR; i++) rem[i] = 5;
    wait_drain(200);
    repeat (4) step();

    // Single requester 0, last beat marked on its third beat.
    t0 = cyc;
`ifdef SFIFO_ARB_BURST_EN
    for (int b = 0; b < 3; b++) push(0, t0 + 1 + b);
`else
    for (int b = 0; b < 3; b++) push(0, t0 + 1 + 2*b);
`endif
    last_mark = 4'b0001;
    rem[0] = 3;
    wait_drain(100);
    chk("a_busy_after_last", busy, 0);
    chk("a_owner", owner, 0);
    last_mark = '0;
    repeat (4) step();

    // Owner 2 with sfifo_full high for five cycles mid-burst.
    t0 = cyc;
`ifdef SFIFO_ARB_BURST_EN
    push(2, t0 + 1); push(2, t0 + 7); push(2, t0 + 8);
    push(2, t0 + 9); push(2, t0 + 11); push(2, t0 + 12);
`else
    push(2, t0 + 1); push(2, t0 + 7); push(2, t0 + 9);
    push(2, t0 + 11); push(2, t0 + 13); push(2, t0 + 15);
`endif
    rem[2] = 6;
    step();
    for (int k = 0; k < 5; k++) begin
      step();
      sfifo_full = 1'b1;
      #1;
      chk("c_stall_gnt", gnt, 0);
      chk("c_stall_wr", sfifo_wr, 0);
    end
    step();
    sfifo_full = 1'b0;
    wait_drain(100);
    repeat (4) step();

    // Owners 1 and 2, two beats each; owner 1 wins after last_owner=2.
    t0 = cyc;
`ifdef SFIFO_ARB_BURST_EN
    push(1, t0 + 1); push(1, t0 + 2); push(2, t0 + 5); push(2, t0 + 6);
    pre = 1;
`else
    push(1, t0 + 1); push(2, t0 + 3); push(1, t0 + 5); push(2, t0 + 7);
    pre = 2;
`endif
    rem[1] = 2;
    rem[2] = 2;
    repeat (4) step();
    chk("d_busy_idle", busy, 0);
    chk("d_owner", owner, pre);
    wait_drain(100);
    repeat (4) step();

    // Reset during owner 3's second beat, then requester 0 is served first.
    t0 = cyc;
`ifdef SFIFO_ARB_BURST_EN
    push(3, t0 + 1);
    pre = 2;
`else
    push(3, t0 + 1); push(0, t0 + 3);
    pre = 5;
`endif
    rem[3] = 4;
    rem[0] = 3;
    repeat (pre) step();
    chk("e_pre_rst_gnt", gnt, 8);
    rst_n = 1'b0;
    #1;
    chk("e_rst_gnt", gnt, 0);
    chk("e_rst_wr", sfifo_wr, 0);
    chk("e_rst_busy", busy, 0);
    chk("e_rst_owner", owner, 0);
    step();
    step();
    rst_n = 1'b1;
    r = cyc;
`ifdef SFIFO_ARB_BURST_EN
    for (int b = 0; b < 3; b++) push(0, r + 1 + b);
    for (int b = 0; b < 3; b++) push(3, r + 6 + b);
`else
    push(0, r + 1); push(3, r + 3); push(0, r + 5);
    push(3, r + 7); push(3, r + 9);
`endif
    wait_drain(100);
    repeat (4) step();

    // Requesters 0 and 1 held together.
    t0 = cyc;
`ifdef SFIFO_ARB_BURST_EN
    for (int b = 0; b < 3; b++) push(0, t0 + 1 + b);
    for (int b = 0; b < 3; b++) push(1, t0 + 6 + b);
`else
    for (int k = 0; k < 6; k++) push(k % 2, t0 + 1 + 2*k);
`endif
    rem[0] = 3;
    rem[1] = 3;
    wait_drain(100);
    repeat (4) step();
    chk("end_busy", busy, 0);
    chk("end_queue_empty", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
